// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with blanking gaps between digits.
// Display data is double-buffered and only swapped in at a frame boundary.
module display_scan_ctrl #(
    parameter int unsigned ON_CYC    = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] datos_in,
    input  logic [3:0]  blank_in,
    input  logic        load_in,
    output logic [6:0]  catodos_o,
    output logic [3:0]  an_o,
    output logic [1:0]  digito_o,
    output logic        frame_o,
    output logic        upd_o
);

    localparam int unsigned MAX_CYC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
    localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    typedef enum logic {StBlank, StOn} state_t;

    state_t      r_state, w_state_d;
    logic [CW-1:0] r_cnt, w_cnt_d;
    logic [1:0]  r_idx, w_idx_d;
    logic [15:0] r_pend_data, r_shadow_data, w_shadow_data_d;
    logic [3:0]  r_pend_blank, r_shadow_blank, w_shadow_blank_d;
    logic        r_pend, w_pend_d;
    logic [6:0]  r_cat, w_cat_d;
    logic [3:0]  r_an, w_an_d;
    logic        r_frame, w_frame;
    logic        r_upd, w_upd;
    logic [3:0]  w_nib;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt + 1'b1;
        w_idx_d   = r_idx;
        w_frame   = 1'b0;
        unique case (r_state)
            StBlank: begin
                if (r_cnt == BLANK_LAST) begin
                    w_state_d = StOn;
                    w_cnt_d   = '0;
                    w_idx_d   = (r_idx == 2'd3) ? 2'd0 : r_idx + 2'd1;
                    w_frame   = (r_idx == 2'd3);
                end
            end
            StOn: begin
                if (r_cnt == ON_LAST) begin
                    w_state_d = StBlank;
                    w_cnt_d   = '0;
                end
            end
            default: ;
        endcase

        // A load on the frame-start edge still applies the older pending value.
        w_upd            = w_frame & r_pend;
        w_pend_d         = load_in | (r_pend & ~w_upd);
        w_shadow_data_d  = w_upd ? r_pend_data  : r_shadow_data;
        w_shadow_blank_d = w_upd ? r_pend_blank : r_shadow_blank;

        // Outputs are computed from next state so they change on the transition edge.
        w_nib   = w_shadow_data_d[w_idx_d*4 +: 4];
        w_an_d  = 4'b1111;
        w_cat_d = 7'h7F;
        if (w_state_d == StOn) begin
            w_an_d  = ~(4'b0001 << w_idx_d);
            w_cat_d = w_shadow_blank_d[w_idx_d] ? 7'h7F : hex7(w_nib);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= StBlank;
            r_cnt          <= '0;
            r_idx          <= 2'd3;
            r_pend_data    <= '0;
            r_pend_blank   <= '0;
            r_pend         <= 1'b0;
            r_shadow_data  <= '0;
            r_shadow_blank <= '0;
            r_cat          <= 7'h7F;
            r_an           <= 4'b1111;
            r_frame        <= 1'b0;
            r_upd          <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_cnt          <= w_cnt_d;
            r_idx          <= w_idx_d;
            r_pend         <= w_pend_d;
            r_shadow_data  <= w_shadow_data_d;
            r_shadow_blank <= w_shadow_blank_d;
            r_cat          <= w_cat_d;
            r_an           <= w_an_d;
            r_frame        <= w_frame;
            r_upd          <= w_upd;
            if (load_in) begin
                r_pend_data  <= datos_in;
                r_pend_blank <= blank_in;
            end
        end
    end

    assign catodos_o = r_cat;
    assign an_o      = r_an;
    assign digito_o  = r_idx;
    assign frame_o   = r_frame;
    assign upd_o     = r_upd;

endmodule
